kernel_launch_ctrl: RTL and testbench
=====================================

KERNEL_LAUNCH_CTRL -- requirements
Module: kernel_launch_ctrl

Interface
REQ-001 Parameter IMEM_AW, default 6, SHALL set the instruction-memory word-address width.
REQ-002 Parameter IMEM_SIZE, default 40, SHALL set the maximum program length in words.
REQ-003 Parameter TIMEOUT, default 4096, SHALL set the maximum RUN cycles (16-bit value, at least 2).
REQ-004 Ports SHALL be:
  clk  in  1  clock; all logic rising-edge.
  rst  in  1  reset, synchronous, active-high.
  prog_valid  in  1  host program beat valid.
  prog_data  in  32  instruction word.
  prog_last  in  1  final beat of program.
  prog_ready  out  1  controller accepts beat.
  host_start  in  1  launch request (level).
  host_done  out  1  one-cycle completion pulse.
  host_idle  out  1  no kernel running.
  status  out  2  0=OK, 1=TIMEOUT, 2=LEN_ERR.
  cycle_count  out  16  RUN cycles of last launch.
  imem_we  out  1  instruction-memory write enable.
  imem_waddr  out  IMEM_AW  word address.
  imem_wdata  out  32  write data.
  core_rst  out  1  core reset (high = held).
  core_start  out  1  one-cycle core start pulse.
  core_done  in  1  core completion (PC index == IMEM_SIZE).

Function
REQ-005 The FSM SHALL have exactly these states: IDLE, LOAD, ARMED, RUN, DONE.
REQ-006 prog_ready SHALL be 1 in IDLE, LOAD and DONE, 0 in ARMED and RUN, and 0 while rst is high.
REQ-007 A beat SHALL be accepted when prog_valid & prog_ready; imem_we SHALL equal that term combinationally, imem_wdata=prog_data, imem_waddr=write pointer.
REQ-008 The first accepted beat in IDLE or DONE SHALL write address 0, clear status to OK, and enter LOAD with the write pointer at 1.
REQ-009 In LOAD, each accepted beat SHALL write at the pointer and increment it.
REQ-010 A beat with prog_last=1 SHALL enter ARMED after its write.
REQ-011 A beat at address IMEM_SIZE-1 with prog_last=0 SHALL enter ARMED and set status=LEN_ERR; excess words are never written.
REQ-012 host_start SHALL be ignored in IDLE and LOAD.
REQ-013 host_start=1 in ARMED or DONE SHALL enter RUN; the write pointer is unchanged, so DONE reruns the loaded program.
REQ-014 Entering RUN SHALL drive core_rst=0 and core_start=1 for exactly one cycle, clear cycle_count to 0, and clear status to OK unless status is LEN_ERR.
REQ-015 In RUN, cycle_count SHALL increment by 1 every cycle.
REQ-016 core_done SHALL be ignored in the first RUN cycle.
REQ-017 core_done=1 in any later RUN cycle SHALL enter DONE with status unchanged.
REQ-018 When cycle_count==TIMEOUT-1 and core_done=0, the FSM SHALL enter DONE with status=TIMEOUT.
REQ-019 When core_done and timeout occur in the same cycle, done SHALL take priority and status stays unchanged.
REQ-020 On entering DONE, core_rst SHALL be 1 and host_done SHALL pulse 1 for one cycle; cycle_count holds.
REQ-021 host_idle SHALL be 0 only in RUN.
REQ-022 core_rst SHALL be 1 in all states except RUN.
REQ-023 All outputs except prog_ready and the imem_* signals SHALL be registered.

Reset
REQ-024 rst=1 SHALL force IDLE, write pointer 0, core_rst=1, core_start=0, host_done=0, host_idle=1, status=0, cycle_count=0, prog_ready=0, imem_we=0, regardless of state, including mid-LOAD or mid-RUN.

Verification
REQ-025 Load 3 beats (last on beat 3), then host_start -> imem writes at addresses 0,1,2; ARMED; core_start pulses 1 cycle; core_rst falls the same cycle.
REQ-026 core_done asserted in RUN cycle 10 -> host_done pulses once, cycle_count=10, status=0, core_rst=1, host_idle=1.
REQ-027 core_done held low, TIMEOUT=16 -> DONE after 16 RUN cycles, status=1, cycle_count=15.
REQ-028 Stream 45 beats with no prog_last, IMEM_SIZE=40 -> 40 writes (addresses 0..39), status=2, prog_ready=0 from beat 41.
REQ-029 host_start in DONE -> rerun without reload; prog_valid in DONE -> new load starting at address 0.
REQ-030 rst pulsed in RUN cycle 5 -> next cycle IDLE with all reset values; subsequent core_done is ignored.

Source files
------------

// File: rtl/kernel_launch_ctrl.sv
// Kernel launch controller: streams a host program into instruction memory,
// then launches the core and supervises it with a cycle counter and timeout.
module kernel_launch_ctrl #(
    parameter int IMEM_AW   = 6,
    parameter int IMEM_SIZE = 40,
    parameter int TIMEOUT   = 4096
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               prog_valid,
    input  logic [31:0]        prog_data,
    input  logic               prog_last,
    output logic               prog_ready,
    input  logic               host_start,
    output logic               host_done,
    output logic               host_idle,
    output logic [1:0]         status,
    output logic [15:0]        cycle_count,
    output logic               imem_we,
    output logic [IMEM_AW-1:0] imem_waddr,
    output logic [31:0]        imem_wdata,
    output logic               core_rst,
    output logic               core_start,
    input  logic               core_done
);

    typedef enum logic [2:0] {IDLE, LOAD, ARMED, RUN, DONE} state_t;

    localparam logic [1:0]         ST_OK      = 2'd0;
    localparam logic [1:0]         ST_TIMEOUT = 2'd1;
    localparam logic [1:0]         ST_LENERR  = 2'd2;
    localparam logic [IMEM_AW-1:0] LAST_ADDR  = IMEM_AW'(IMEM_SIZE - 1);
    localparam logic [15:0]        CNT_LIMIT  = 16'(TIMEOUT - 1);

    state_t             state_q, state_d;
    logic [IMEM_AW-1:0] wptr_q, wptr_d;
    logic [1:0]         status_q, status_d;
    logic [15:0]        cnt_q, cnt_d;
    logic               core_rst_q, core_start_q, host_done_q, host_idle_q;
    logic               accept, launch;
    logic [IMEM_AW-1:0] waddr;

    // A fresh load from IDLE or DONE always restarts at address 0, even though
    // DONE keeps the old pointer around for reruns.
    always_comb begin
        prog_ready = ~rst & ((state_q == IDLE) | (state_q == LOAD) | (state_q == DONE));
        accept     = prog_valid & prog_ready;
        waddr      = (state_q == LOAD) ? wptr_q : '0;
        imem_we    = accept;
        imem_waddr = waddr;
        imem_wdata = prog_data;
    end

    always_comb begin
        state_d  = state_q;
        wptr_d   = wptr_q;
        status_d = status_q;
        cnt_d    = cnt_q;
        launch   = 1'b0;
        case (state_q)
            IDLE, LOAD, DONE: begin
                if (accept) begin
                    wptr_d = waddr + IMEM_AW'(1);
                    if (state_q != LOAD) status_d = ST_OK;
                    if (prog_last) begin
                        state_d = ARMED;
                    end else if (waddr == LAST_ADDR) begin
                        state_d  = ARMED;
                        status_d = ST_LENERR;
                    end else begin
                        state_d = LOAD;
                    end
                end else if (state_q == DONE && host_start) begin
                    launch = 1'b1;
                end
            end
            ARMED: begin
                if (host_start) launch = 1'b1;
            end
            RUN: begin
                // core_start_q is high exactly in the first RUN cycle, where
                // a stale core_done from the previous run must be ignored.
                if (core_done && !core_start_q) begin
                    state_d = DONE;
                end else if (cnt_q == CNT_LIMIT) begin
                    state_d  = DONE;
                    status_d = ST_TIMEOUT;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            default: state_d = IDLE;
        endcase
        if (launch) begin
            state_d = RUN;
            cnt_d   = '0;
            if (status_q != ST_LENERR) status_d = ST_OK;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            wptr_q       <= '0;
            status_q     <= ST_OK;
            cnt_q        <= '0;
            core_rst_q   <= 1'b1;
            core_start_q <= 1'b0;
            host_done_q  <= 1'b0;
            host_idle_q  <= 1'b1;
        end else begin
            state_q      <= state_d;
            wptr_q       <= wptr_d;
            status_q     <= status_d;
            cnt_q        <= cnt_d;
            core_rst_q   <= (state_d != RUN);
            core_start_q <= launch;
            host_done_q  <= (state_q == RUN) && (state_d == DONE);
            host_idle_q  <= (state_d != RUN);
        end
    end

    assign status      = status_q;
    assign cycle_count = cnt_q;
    assign core_rst    = core_rst_q;
    assign core_start  = core_start_q;
    assign host_done   = host_done_q;
    assign host_idle   = host_idle_q;

endmodule

// File: tb/tb_kernel_launch_ctrl.sv
// Directed bench for kernel_launch_ctrl: load, launch, done, timeout,
// over-length program, rerun from DONE and reset during RUN.
module tb_kernel_launch_ctrl;

    localparam int IMEM_AW   = 6;
    localparam int IMEM_SIZE = 40;
    localparam int TIMEOUT   = 16;

    logic               clk = 1'b0;
    logic               rst;
    logic               prog_valid;
    logic [31:0]        prog_data;
    logic               prog_last;
    logic               prog_ready;
    logic               host_start;
    logic               host_done;
    logic               host_idle;
    logic [1:0]         status;
    logic [15:0]        cycle_count;
    logic               imem_we;
    logic [IMEM_AW-1:0] imem_waddr;
    logic [31:0]        imem_wdata;
    logic               core_rst;
    logic               core_start;
    logic               core_done;

    int n_checks = 0;
    int n_errors = 0;
    int n_writes;

    always #5 clk = ~clk;

    kernel_launch_ctrl #(
        .IMEM_AW  (IMEM_AW),
        .IMEM_SIZE(IMEM_SIZE),
        .TIMEOUT  (TIMEOUT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .prog_valid (prog_valid),
        .prog_data  (prog_data),
        .prog_last  (prog_last),
        .prog_ready (prog_ready),
        .host_start (host_start),
        .host_done  (host_done),
        .host_idle  (host_idle),
        .status     (status),
        .cycle_count(cycle_count),
        .imem_we    (imem_we),
        .imem_waddr (imem_waddr),
        .imem_wdata (imem_wdata),
        .core_rst   (core_rst),
        .core_start (core_start),
        .core_done  (core_done)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; prog_valid = 1'b0; prog_data = '0; prog_last = 1'b0;
        host_start = 1'b0; core_done = 1'b0;

        // reset values, with a beat offered while rst is high
        step(); step();
        prog_valid = 1'b1;
        #1;
        chk("rst_prog_ready", {31'd0, prog_ready}, 32'd0);
        chk("rst_imem_we", {31'd0, imem_we}, 32'd0);
        chk("rst_core_rst", {31'd0, core_rst}, 32'd1);
        chk("rst_core_start", {31'd0, core_start}, 32'd0);
        chk("rst_host_done", {31'd0, host_done}, 32'd0);
        chk("rst_host_idle", {31'd0, host_idle}, 32'd1);
        chk("rst_status", {30'd0, status}, 32'd0);
        chk("rst_cycle_count", {16'd0, cycle_count}, 32'd0);
        prog_valid = 1'b0;
        rst = 1'b0;
        step();
        chk("idle_prog_ready", {31'd0, prog_ready}, 32'd1);

        // host_start ignored in IDLE
        host_start = 1'b1;
        step(); step();
        host_start = 1'b0;
        chk("idle_start_ignored", {31'd0, core_start}, 32'd0);
        chk("idle_start_host_idle", {31'd0, host_idle}, 32'd1);

        // three-beat program, host_start pulsed mid-load must be ignored
        for (int i = 0; i < 3; i++) begin
            prog_valid = 1'b1;
            prog_data  = 32'hA000_0000 + i;
            prog_last  = (i == 2);
            host_start = (i == 1);
            #1;
            chk($sformatf("load3_we_%0d", i), {31'd0, imem_we}, 32'd1);
            chk($sformatf("load3_addr_%0d", i), {26'd0, imem_waddr}, i);
            chk($sformatf("load3_data_%0d", i), imem_wdata, 32'hA000_0000 + i);
            step();
            host_start = 1'b0;
            chk($sformatf("load3_no_run_%0d", i), {31'd0, host_idle}, 32'd1);
        end
        prog_valid = 1'b1; prog_last = 1'b0;
        #1;
        chk("armed_prog_ready", {31'd0, prog_ready}, 32'd0);
        chk("armed_imem_we", {31'd0, imem_we}, 32'd0);
        prog_valid = 1'b0;

        // launch, core_done in first RUN cycle ignored, done in RUN cycle 10
        host_start = 1'b1;
        step();
        host_start = 1'b0;
        chk("run0_core_start", {31'd0, core_start}, 32'd1);
        chk("run0_core_rst", {31'd0, core_rst}, 32'd0);
        chk("run0_host_idle", {31'd0, host_idle}, 32'd0);
        chk("run0_count", {16'd0, cycle_count}, 32'd0);
        core_done = 1'b1;
        step();
        core_done = 1'b0;
        chk("run1_start_cleared", {31'd0, core_start}, 32'd0);
        chk("run1_first_done_ignored", {31'd0, host_idle}, 32'd0);
        chk("run1_count", {16'd0, cycle_count}, 32'd1);
        for (int i = 0; i < 9; i++) step();
        chk("run10_count", {16'd0, cycle_count}, 32'd10);
        core_done = 1'b1;
        step();
        core_done = 1'b0;
        chk("done_host_done", {31'd0, host_done}, 32'd1);
        chk("done_count", {16'd0, cycle_count}, 32'd10);
        chk("done_status", {30'd0, status}, 32'd0);
        chk("done_core_rst", {31'd0, core_rst}, 32'd1);
        chk("done_host_idle", {31'd0, host_idle}, 32'd1);
        step();
        chk("done_pulse_once", {31'd0, host_done}, 32'd0);
        chk("done_count_hold", {16'd0, cycle_count}, 32'd10);
        chk("done_prog_ready", {31'd0, prog_ready}, 32'd1);

        // rerun from DONE without reload, let it time out
        host_start = 1'b1;
        step();
        host_start = 1'b0;
        chk("rerun_core_start", {31'd0, core_start}, 32'd1);
        chk("rerun_count_clr", {16'd0, cycle_count}, 32'd0);
        for (int i = 0; i < 15; i++) step();
        chk("to_last_run_count", {16'd0, cycle_count}, 32'd15);
        chk("to_still_running", {31'd0, host_idle}, 32'd0);
        step();
        chk("to_host_done", {31'd0, host_done}, 32'd1);
        chk("to_status", {30'd0, status}, 32'd1);
        chk("to_count", {16'd0, cycle_count}, 32'd15);
        chk("to_core_rst", {31'd0, core_rst}, 32'd1);

        // 45 beats without prog_last from DONE: 40 writes then LEN_ERR
        n_writes = 0;
        for (int i = 0; i < 45; i++) begin
            prog_valid = 1'b1;
            prog_data  = 32'hB000_0000 + i;
            prog_last  = 1'b0;
            #1;
            chk($sformatf("long_ready_%0d", i), {31'd0, prog_ready}, (i < IMEM_SIZE) ? 32'd1 : 32'd0);
            if (imem_we) begin
                n_writes++;
                chk($sformatf("long_addr_%0d", i), {26'd0, imem_waddr}, i);
            end
            step();
            if (i == 0) chk("long_status_cleared", {30'd0, status}, 32'd0);
        end
        prog_valid = 1'b0;
        chk("long_write_count", n_writes, 32'd40);
        chk("long_status", {30'd0, status}, 32'd2);

        // LEN_ERR survives launch; reset in RUN cycle 5
        host_start = 1'b1;
        step();
        host_start = 1'b0;
        chk("lenerr_run_status", {30'd0, status}, 32'd2);
        for (int i = 0; i < 5; i++) step();
        chk("rr_count5", {16'd0, cycle_count}, 32'd5);
        rst = 1'b1;
        #1;
        chk("rr_prog_ready_in_rst", {31'd0, prog_ready}, 32'd0);
        step();
        rst = 1'b0;
        chk("rr_status", {30'd0, status}, 32'd0);
        chk("rr_count", {16'd0, cycle_count}, 32'd0);
        chk("rr_core_rst", {31'd0, core_rst}, 32'd1);
        chk("rr_host_idle", {31'd0, host_idle}, 32'd1);
        #1;
        chk("rr_idle_ready", {31'd0, prog_ready}, 32'd1);
        core_done = 1'b1;
        step(); step();
        core_done = 1'b0;
        chk("rr_done_ignored", {31'd0, host_done}, 32'd0);
        chk("rr_no_start", {31'd0, core_start}, 32'd0);
        chk("rr_still_idle", {31'd0, host_idle}, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
